// File: rtl/fetch_stage.sv
// fetch_stage: IF stage -- owns the PC, prefetches from 1-cycle imem, presents {ir, pc, valid} to ID
//   clk, reset (async active-low)
//   instr_addr/instr_stall/instr_clear -> imem, instr_in <- imem (data one cycle after issue)
//   stall_id, redirect, redirect_pc <- ID/EX; ir_ID, pc_ID, valid_ID -> ID
module fetch_stage #(
    parameter logic [31:0] pc_init = 32'h8002_0000,
    parameter int          depth   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_in,
    output logic        instr_stall,
    output logic        instr_clear,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir_ID,
    output logic [31:0] pc_ID,
    output logic        valid_ID
);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    logic [31:0]   pc, req_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] head, tail;
    logic [31:0]   q_ir [depth];
    logic [31:0]   q_pc [depth];
    logic          pop, push, issue;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == depth - 1) ? '0 : p + 1'b1;
    endfunction
    // The in-flight read already owns a queue slot, so it counts toward occupancy.
    always_comb begin
        valid_ID    = count != '0;
        pop         = valid_ID & ~stall_id & ~redirect;
        push        = inflight & ~redirect;
        issue       = reset & ~redirect & (int'(count) + int'(inflight) < depth + int'(pop));
        instr_stall = ~issue;
        instr_clear = redirect;
        instr_addr  = pc;
        ir_ID       = valid_ID ? q_ir[head] : '0;
        pc_ID       = valid_ID ? q_pc[head] : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= pc_init;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            for (int i = 0; i < depth; i++) begin
                q_ir[i] <= '0;
                q_pc[i] <= '0;
            end
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            inflight <= issue;
            if (push) begin
                q_ir[tail] <= instr_in;
                q_pc[tail] <= req_pc;
                tail       <= nxt(tail);
            end
            if (pop)
                head <= nxt(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
